mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
Initiator side of the cache-to-main-memory request/response protocol. Accepts block-miss requests from the icache and the dcache, arbitrates between them, and issues one request per cycle to the pipelined main memory. Responses are returned in order and tagged with a cache type; the block uses that tag to route each response back to the requesting cache. Each cache may have at most one outstanding request.

Parameters:
ADDR_WIDTH, 10, block address width; matches main-memory block count (`MAIN_MEM_N_BLOCKS = 2^ADDR_WIDTH).
BLOCK_WIDTH, 512, block data width in bits (block_data_t).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ic_req_valid  in  1  icache miss request (read only)
ic_req_ready  out  1  icache request accepted when valid&&ready
ic_req_block_addr  in  ADDR_WIDTH  icache block address
dc_req_valid  in  1  dcache request
dc_req_ready  out  1  dcache request accepted when valid&&ready
dc_req_type  in  1  req_type_t: 0 READ, 1 WRITE
dc_req_block_addr  in  ADDR_WIDTH  dcache block address
dc_req_block_data  in  BLOCK_WIDTH  write data
ic_resp_valid  out  1  one-cycle pulse; icache fill data valid
ic_resp_block_data  out  BLOCK_WIDTH  icache fill data
dc_resp_valid  out  1  one-cycle pulse; read data or write acknowledge
dc_resp_block_data  out  BLOCK_WIDTH  dcache read data (don't-care for writes)
mem_req_valid  out  1  request to main memory
mem_req_cache_type  out  1  cache_type_t: 0 ICACHE, 1 DCACHE
mem_req_type  out  1  req_type_t
mem_req_block_addr  out  ADDR_WIDTH  block address
mem_req_block_data  out  BLOCK_WIDTH  write data
mem_resp_valid  in  1  response from main memory
mem_resp_cache_type  in  1  response tag
mem_resp_block_data  in  BLOCK_WIDTH  response data
protocol_err  out  1  sticky; set on an unexpected response

Behaviour:
- Per-cache FSM (ic, dc), each with states IDLE, PENDING, WAIT.
  - IDLE: req_ready=1. valid&&ready at edge -> latch addr, type and data into the per-cache buffer -> PENDING.
  - PENDING: req_ready=0. Eligible for grant.
  - Granted -> WAIT.
  - WAIT: req_ready=0. On mem_resp_valid with a matching tag -> IDLE.
- A cache is never re-accepted in the same cycle its response arrives; ready rises the cycle after it returns to IDLE.
- Arbiter:
  - At most one grant per cycle, among caches in PENDING.
  - Round-robin priority pointer; resets to icache. After a grant, priority moves to the other cache.
  - With a single contender, that contender is granted immediately.
- mem_req_* are combinational from the granted buffer. mem_req_valid=1 only in the grant cycle; main memory has no backpressure. With no grant: mem_req_valid=0, other mem_req_* = 0.
- icache requests always issue with mem_req_type=READ and mem_req_block_data=0.
- Latency: request accepted at edge T -> mem_req_valid at the earliest in cycle T+1 (one cycle later per losing arbitration). Response sampled at edge R -> {ic,dc}_resp_valid high in cycle R+1 for exactly one cycle, with data registered from mem_resp_block_data.
- A dcache WRITE also produces a dc_resp_valid pulse, which acts as the completion acknowledge.
- With both caches outstanding, the two responses arrive in issue order. Routing is by tag only.
- Unexpected response (tag names a cache in IDLE or PENDING):
  - The response is dropped; no resp pulse.
  - protocol_err is set to 1 and stays 1 until reset.
  - The addressed cache's FSM state is unchanged.
- Reset (synchronous; applies whenever rst=1 at an edge, including mid-operation):
  - Both FSMs -> IDLE, pointer -> icache, protocol_err=0, ic/dc_resp_valid=0, resp data=0.
  - The integrator resets main memory together with this block, so that in-flight responses are flushed.
- Outputs after reset:
  - ic_req_ready=1, dc_req_ready=1.
  - mem_req_valid=0, with all mem_req_* fields = 0.

Test Plan:
- Reset: hold rst 2 cycles -> ic/dc_req_ready=1, mem_req_valid=0, ic/dc_resp_valid=0, protocol_err=0.
- Single icache read, addr 0x005: accept at T -> mem_req_valid=1, cache_type=0, type=0, addr=0x005 in T+1; main memory returns 0xAA..AA -> ic_resp_valid one pulse with 0xAA..AA; ic_req_ready low from T+1 until the cycle after the response.
- Simultaneous requests from reset (ic addr 0x010, dc read addr 0x020) -> icache issued in cycle T+1, dcache in T+2; responses routed correctly; next simultaneous pair -> dcache issued first.
- dcache WRITE addr 0x030 data 0x1234, then dcache READ 0x030 -> write produces a dc_resp_valid ack; read returns 0x1234.
- Inject mem_resp_valid with tag DCACHE while dcache is IDLE -> no dc_resp_valid; protocol_err=1 and stays set; cleared only by rst.
- Reset asserted while icache is in WAIT -> next cycle ic_req_ready=1 and mem_req_valid=0; a new request completes normally.

Source files
------------

// File: rtl/mem_ctrl.sv
// Initiator side of the cache-to-main-memory protocol: buffers one miss per
// cache, round-robin arbitrates onto pipelined memory, routes tagged responses.
module mem_ctrl #(
    parameter int ADDR_WIDTH  = 10,
    parameter int BLOCK_WIDTH = 512
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   ic_req_valid,
    output logic                   ic_req_ready,
    input  logic [ADDR_WIDTH-1:0]  ic_req_block_addr,

    input  logic                   dc_req_valid,
    output logic                   dc_req_ready,
    input  logic                   dc_req_type,
    input  logic [ADDR_WIDTH-1:0]  dc_req_block_addr,
    input  logic [BLOCK_WIDTH-1:0] dc_req_block_data,

    output logic                   ic_resp_valid,
    output logic [BLOCK_WIDTH-1:0] ic_resp_block_data,
    output logic                   dc_resp_valid,
    output logic [BLOCK_WIDTH-1:0] dc_resp_block_data,

    output logic                   mem_req_valid,
    output logic                   mem_req_cache_type,
    output logic                   mem_req_type,
    output logic [ADDR_WIDTH-1:0]  mem_req_block_addr,
    output logic [BLOCK_WIDTH-1:0] mem_req_block_data,

    input  logic                   mem_resp_valid,
    input  logic                   mem_resp_cache_type,
    input  logic [BLOCK_WIDTH-1:0] mem_resp_block_data,

    output logic                   protocol_err
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PENDING = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;

    localparam logic CACHE_IC = 1'b0;
    localparam logic CACHE_DC = 1'b1;
    localparam logic REQ_READ = 1'b0;

    logic [1:0]             ic_state;
    logic [1:0]             dc_state;
    logic [ADDR_WIDTH-1:0]  ic_addr;
    logic                   dc_type;
    logic [ADDR_WIDTH-1:0]  dc_addr;
    logic [BLOCK_WIDTH-1:0] dc_data;
    logic                   prio;
    logic                   grant_ic;
    logic                   grant_dc;
    logic                   ic_resp_hit;
    logic                   dc_resp_hit;

    assign ic_req_ready = (ic_state == ST_IDLE);
    assign dc_req_ready = (dc_state == ST_IDLE);

    assign ic_resp_hit = mem_resp_valid && (mem_resp_cache_type == CACHE_IC);
    assign dc_resp_hit = mem_resp_valid && (mem_resp_cache_type == CACHE_DC);

    // A lone contender wins outright; the pointer only breaks ties.
    always_comb begin
        grant_ic = 1'b0;
        grant_dc = 1'b0;
        if (ic_state == ST_PENDING && dc_state == ST_PENDING) begin
            grant_ic = (prio == CACHE_IC);
            grant_dc = (prio == CACHE_DC);
        end else begin
            grant_ic = (ic_state == ST_PENDING);
            grant_dc = (dc_state == ST_PENDING);
        end
    end

    always_comb begin
        mem_req_valid      = 1'b0;
        mem_req_cache_type = CACHE_IC;
        mem_req_type       = REQ_READ;
        mem_req_block_addr = '0;
        mem_req_block_data = '0;
        if (grant_ic) begin
            mem_req_valid      = 1'b1;
            mem_req_block_addr = ic_addr;
        end else if (grant_dc) begin
            mem_req_valid      = 1'b1;
            mem_req_cache_type = CACHE_DC;
            mem_req_type       = dc_type;
            mem_req_block_addr = dc_addr;
            mem_req_block_data = dc_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ic_state <= ST_IDLE;
            ic_addr  <= '0;
        end else begin
            case (ic_state)
                ST_IDLE: begin
                    if (ic_req_valid) begin
                        ic_addr  <= ic_req_block_addr;
                        ic_state <= ST_PENDING;
                    end
                end
                ST_PENDING: if (grant_ic) ic_state <= ST_WAIT;
                ST_WAIT:    if (ic_resp_hit) ic_state <= ST_IDLE;
                default:    ic_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dc_state <= ST_IDLE;
            dc_type  <= REQ_READ;
            dc_addr  <= '0;
            dc_data  <= '0;
        end else begin
            case (dc_state)
                ST_IDLE: begin
                    if (dc_req_valid) begin
                        dc_type  <= dc_req_type;
                        dc_addr  <= dc_req_block_addr;
                        dc_data  <= dc_req_block_data;
                        dc_state <= ST_PENDING;
                    end
                end
                ST_PENDING: if (grant_dc) dc_state <= ST_WAIT;
                ST_WAIT:    if (dc_resp_hit) dc_state <= ST_IDLE;
                default:    dc_state <= ST_IDLE;
            endcase
        end
    end

    // Responses tagged for a cache that is not waiting are dropped and flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio               <= CACHE_IC;
            protocol_err       <= 1'b0;
            ic_resp_valid      <= 1'b0;
            dc_resp_valid      <= 1'b0;
            ic_resp_block_data <= '0;
            dc_resp_block_data <= '0;
        end else begin
            ic_resp_valid <= 1'b0;
            dc_resp_valid <= 1'b0;
            if (grant_ic) begin
                prio <= CACHE_DC;
            end else if (grant_dc) begin
                prio <= CACHE_IC;
            end
            if (ic_resp_hit) begin
                if (ic_state == ST_WAIT) begin
                    ic_resp_valid      <= 1'b1;
                    ic_resp_block_data <= mem_resp_block_data;
                end else begin
                    protocol_err <= 1'b1;
                end
            end
            if (dc_resp_hit) begin
                if (dc_state == ST_WAIT) begin
                    dc_resp_valid      <= 1'b1;
                    dc_resp_block_data <= mem_resp_block_data;
                end else begin
                    protocol_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: the bench plays both caches and main memory,
// driving inputs and sampling outputs 1ns after each rising edge.
module tb_mem_ctrl;

    localparam int AW = 10;
    localparam int BW = 512;

    logic          clk = 1'b0;
    logic          rst;
    logic          ic_req_valid;
    logic          ic_req_ready;
    logic [AW-1:0] ic_req_block_addr;
    logic          dc_req_valid;
    logic          dc_req_ready;
    logic          dc_req_type;
    logic [AW-1:0] dc_req_block_addr;
    logic [BW-1:0] dc_req_block_data;
    logic          ic_resp_valid;
    logic [BW-1:0] ic_resp_block_data;
    logic          dc_resp_valid;
    logic [BW-1:0] dc_resp_block_data;
    logic          mem_req_valid;
    logic          mem_req_cache_type;
    logic          mem_req_type;
    logic [AW-1:0] mem_req_block_addr;
    logic [BW-1:0] mem_req_block_data;
    logic          mem_resp_valid;
    logic          mem_resp_cache_type;
    logic [BW-1:0] mem_resp_block_data;
    logic          protocol_err;

    int num_checks = 0;
    int num_failures = 0;

    logic [BW-1:0] pat_aa;
    logic [BW-1:0] pat_ic;
    logic [BW-1:0] pat_dc;
    logic [BW-1:0] wr_data;
    logic [BW-1:0] mem_word;

    mem_ctrl #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .ic_req_valid        (ic_req_valid),
        .ic_req_ready        (ic_req_ready),
        .ic_req_block_addr   (ic_req_block_addr),
        .dc_req_valid        (dc_req_valid),
        .dc_req_ready        (dc_req_ready),
        .dc_req_type         (dc_req_type),
        .dc_req_block_addr   (dc_req_block_addr),
        .dc_req_block_data   (dc_req_block_data),
        .ic_resp_valid       (ic_resp_valid),
        .ic_resp_block_data  (ic_resp_block_data),
        .dc_resp_valid       (dc_resp_valid),
        .dc_resp_block_data  (dc_resp_block_data),
        .mem_req_valid       (mem_req_valid),
        .mem_req_cache_type  (mem_req_cache_type),
        .mem_req_type        (mem_req_type),
        .mem_req_block_addr  (mem_req_block_addr),
        .mem_req_block_data  (mem_req_block_data),
        .mem_resp_valid      (mem_resp_valid),
        .mem_resp_cache_type (mem_resp_cache_type),
        .mem_resp_block_data (mem_resp_block_data),
        .protocol_err        (protocol_err)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [BW-1:0] observed,
                                input logic [BW-1:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic icv, input logic [AW-1:0] ica,
                                  input logic dcv, input logic dct,
                                  input logic [AW-1:0] dca, input logic [BW-1:0] dcd);
        ic_req_valid      = icv;
        ic_req_block_addr = ica;
        dc_req_valid      = dcv;
        dc_req_type       = dct;
        dc_req_block_addr = dca;
        dc_req_block_data = dcd;
        step();
        ic_req_valid = 1'b0;
        dc_req_valid = 1'b0;
    endtask

    task automatic mem_respond(input logic tag, input logic [BW-1:0] data);
        mem_resp_valid      = 1'b1;
        mem_resp_cache_type = tag;
        mem_resp_block_data = data;
        step();
        mem_resp_valid      = 1'b0;
        mem_resp_block_data = '0;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) step();
        rst = 1'b0;
    endtask

    task automatic check_issue(input string tag, input logic ctype, input logic rtype,
                               input logic [AW-1:0] addr, input logic [BW-1:0] data);
        check_output({tag, "_valid"}, BW'(mem_req_valid), BW'(1'b1));
        check_output({tag, "_ctype"}, BW'(mem_req_cache_type), BW'(ctype));
        check_output({tag, "_rtype"}, BW'(mem_req_type), BW'(rtype));
        check_output({tag, "_addr"}, BW'(mem_req_block_addr), BW'(addr));
        check_output({tag, "_data"}, mem_req_block_data, data);
    endtask

    task automatic check_idle_bus(input string tag);
        check_output({tag, "_valid"}, BW'(mem_req_valid), BW'(1'b0));
        check_output({tag, "_addr"}, BW'(mem_req_block_addr), BW'(0));
        check_output({tag, "_data"}, mem_req_block_data, BW'(0));
    endtask

    initial begin
        pat_aa  = {64{8'hAA}};
        pat_ic  = {32{16'hC0DE}};
        pat_dc  = {32{16'hD00D}};
        wr_data = BW'(16'h1234);
        rst = 1'b1;
        ic_req_valid = 1'b0;
        ic_req_block_addr = '0;
        dc_req_valid = 1'b0;
        dc_req_type = 1'b0;
        dc_req_block_addr = '0;
        dc_req_block_data = '0;
        mem_resp_valid = 1'b0;
        mem_resp_cache_type = 1'b0;
        mem_resp_block_data = '0;

        // Reset values
        do_reset(2);
        check_output("rst_ic_ready", BW'(ic_req_ready), BW'(1'b1));
        check_output("rst_dc_ready", BW'(dc_req_ready), BW'(1'b1));
        check_output("rst_ic_resp", BW'(ic_resp_valid), BW'(1'b0));
        check_output("rst_dc_resp", BW'(dc_resp_valid), BW'(1'b0));
        check_output("rst_err", BW'(protocol_err), BW'(1'b0));
        check_idle_bus("rst_bus");

        // Single icache read
        apply_stimulus(1'b1, 10'h005, 1'b0, 1'b0, '0, '0);
        check_issue("ic1", 1'b0, 1'b0, 10'h005, '0);
        check_output("ic1_ready_pend", BW'(ic_req_ready), BW'(1'b0));
        step();
        check_idle_bus("ic1_after");
        check_output("ic1_ready_wait", BW'(ic_req_ready), BW'(1'b0));
        mem_respond(1'b0, pat_aa);
        check_output("ic1_resp_valid", BW'(ic_resp_valid), BW'(1'b1));
        check_output("ic1_resp_data", ic_resp_block_data, pat_aa);
        check_output("ic1_no_dc_resp", BW'(dc_resp_valid), BW'(1'b0));
        check_output("ic1_ready_back", BW'(ic_req_ready), BW'(1'b1));
        step();
        check_output("ic1_pulse_end", BW'(ic_resp_valid), BW'(1'b0));

        // Simultaneous pair from reset: icache wins first
        do_reset(1);
        apply_stimulus(1'b1, 10'h010, 1'b1, 1'b0, 10'h020, '0);
        check_issue("pair1_first", 1'b0, 1'b0, 10'h010, '0);
        step();
        check_issue("pair1_second", 1'b1, 1'b0, 10'h020, '0);
        step();
        check_idle_bus("pair1_done");
        mem_respond(1'b0, pat_ic);
        check_output("pair1_ic_resp", BW'(ic_resp_valid), BW'(1'b1));
        check_output("pair1_ic_data", ic_resp_block_data, pat_ic);
        check_output("pair1_dc_quiet", BW'(dc_resp_valid), BW'(1'b0));
        mem_respond(1'b1, pat_dc);
        check_output("pair1_dc_resp", BW'(dc_resp_valid), BW'(1'b1));
        check_output("pair1_dc_data", dc_resp_block_data, pat_dc);
        check_output("pair1_ic_quiet", BW'(ic_resp_valid), BW'(1'b0));

        // Lone icache grant hands priority to the dcache for the next tie
        apply_stimulus(1'b1, 10'h011, 1'b0, 1'b0, '0, '0);
        check_issue("solo_ic", 1'b0, 1'b0, 10'h011, '0);
        step();
        mem_respond(1'b0, pat_aa);
        check_output("solo_ic_resp", BW'(ic_resp_valid), BW'(1'b1));
        apply_stimulus(1'b1, 10'h012, 1'b1, 1'b0, 10'h022, '0);
        check_issue("pair2_first", 1'b1, 1'b0, 10'h022, '0);
        step();
        check_issue("pair2_second", 1'b0, 1'b0, 10'h012, '0);
        step();
        mem_respond(1'b1, pat_dc);
        check_output("pair2_dc_resp", BW'(dc_resp_valid), BW'(1'b1));
        check_output("pair2_dc_data", dc_resp_block_data, pat_dc);
        mem_respond(1'b0, pat_ic);
        check_output("pair2_ic_resp", BW'(ic_resp_valid), BW'(1'b1));
        check_output("pair2_ic_data", ic_resp_block_data, pat_ic);

        // dcache write then read-back through a one-word memory model
        apply_stimulus(1'b0, '0, 1'b1, 1'b1, 10'h030, wr_data);
        check_issue("dc_wr", 1'b1, 1'b1, 10'h030, wr_data);
        mem_word = mem_req_block_data;
        step();
        mem_respond(1'b1, '0);
        check_output("dc_wr_ack", BW'(dc_resp_valid), BW'(1'b1));
        check_output("dc_wr_ready", BW'(dc_req_ready), BW'(1'b1));
        apply_stimulus(1'b0, '0, 1'b1, 1'b0, 10'h030, '0);
        check_issue("dc_rd", 1'b1, 1'b0, 10'h030, '0);
        step();
        mem_respond(1'b1, mem_word);
        check_output("dc_rd_resp", BW'(dc_resp_valid), BW'(1'b1));
        check_output("dc_rd_data", dc_resp_block_data, wr_data);
        step();

        // Unexpected dcache response while dcache is idle
        mem_respond(1'b1, {64{8'hFF}});
        check_output("unexp_no_resp", BW'(dc_resp_valid), BW'(1'b0));
        check_output("unexp_data_kept", dc_resp_block_data, wr_data);
        check_output("unexp_err", BW'(protocol_err), BW'(1'b1));
        check_output("unexp_dc_ready", BW'(dc_req_ready), BW'(1'b1));
        for (int i = 0; i < 3; i++) step();
        check_output("unexp_err_sticky", BW'(protocol_err), BW'(1'b1));
        do_reset(1);
        check_output("unexp_err_cleared", BW'(protocol_err), BW'(1'b0));

        // Reset while the icache is waiting on memory
        apply_stimulus(1'b1, 10'h040, 1'b0, 1'b0, '0, '0);
        step();
        check_output("midrst_waiting", BW'(ic_req_ready), BW'(1'b0));
        do_reset(1);
        check_output("midrst_ready", BW'(ic_req_ready), BW'(1'b1));
        check_idle_bus("midrst_bus");
        apply_stimulus(1'b1, 10'h041, 1'b0, 1'b0, '0, '0);
        check_issue("midrst_new", 1'b0, 1'b0, 10'h041, '0);
        step();
        mem_respond(1'b0, pat_ic);
        check_output("midrst_resp", BW'(ic_resp_valid), BW'(1'b1));
        check_output("midrst_data", ic_resp_block_data, pat_ic);
        check_output("midrst_no_err", BW'(protocol_err), BW'(1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", num_checks, num_failures);
        $finish;
    end

endmodule
